psram_arbiter: RTL and testbench

Shares the single asynchronous PSRAM byte controller between three requesters: the game loader, the CPU (read/write), and the PPU (read). It sits between those requesters and the memory controller's `read_a`/`read_b`/`write` strobes. It buffers loader write pulses, grants one transaction at a time by fixed priority with a CPU anti-starvation guard, and returns read data with a per-requester valid pulse.

---
 rtl/psram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_psram_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : psram_arbiter
// Purpose  : Shares one PSRAM byte controller between loader, CPU and PPU
//            with a loader FIFO, fixed priority and a CPU starvation guard.
// Revision : 1.0
// ============================================================================
module psram_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ldr_wr,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_data,
  output logic              ldr_overflow,
  input  logic              cpu_rd_req,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ppu_rd_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_ack,
  output logic [7:0]        ppu_rdata,
  output logic              ppu_rvalid,
  output logic              mc_read_a,
  output logic              mc_read_b,
  output logic              mc_write,
  output logic [23:0]       mc_addr,
  output logic [7:0]        mc_din,
  input  logic              mc_busy,
  input  logic [7:0]        mc_dout_a,
  input  logic [7:0]        mc_dout_b,
  output logic              proto_err
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_issued = 2'd1;
  localparam logic [1:0] c_st_busy   = 2'd2;
  localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);

  logic [1:0]        r_state, w_state_next;
  logic [ADDR_W-1:0] r_fifo_addr [2];
  logic [7:0]        r_fifo_data [2];
  logic              r_wptr, r_rptr;
  logic [1:0]        r_count;
  logic              r_ldr_overflow, r_proto_err;
  logic              r_op_cpu_rd, r_op_ppu_rd;
  logic [7:0]        r_cpu_rdata, r_ppu_rdata;
  logic              r_cpu_rvalid, r_ppu_rvalid;
  logic [2:0]        r_starve;

  logic              w_gnt_ldr, w_gnt_cpu_wr, w_gnt_cpu_rd, w_gnt_ppu, w_any_gnt;
  logic              w_cpu_pend, w_fifo_full, w_fifo_empty, w_enq, w_deq;
  logic [ADDR_W-1:0] w_sel_addr;

  assign w_cpu_pend   = cpu_rd_req | cpu_wr_req;
  assign w_fifo_full  = (r_count == 2'd2);
  assign w_fifo_empty = (r_count == 2'd0);
  assign w_deq        = w_gnt_ldr;
  // A full FIFO still accepts a pulse when its head leaves in the same cycle.
  assign w_enq        = ldr_wr & (~w_fifo_full | w_deq);
  assign w_any_gnt    = w_gnt_ldr | w_gnt_cpu_wr | w_gnt_cpu_rd | w_gnt_ppu;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_next;
  end

  // Grant decision and next state; nothing issues while the controller is busy.
  always_comb begin
    w_gnt_ldr    = 1'b0;
    w_gnt_cpu_wr = 1'b0;
    w_gnt_cpu_rd = 1'b0;
    w_gnt_ppu    = 1'b0;
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (!reset && !mc_busy) begin
          if (!w_fifo_empty)                                   w_gnt_ldr    = 1'b1;
          else if (w_cpu_pend && r_starve >= c_starve_limit) begin
            if (cpu_wr_req)                                    w_gnt_cpu_wr = 1'b1;
            else                                               w_gnt_cpu_rd = 1'b1;
          end
          else if (ppu_rd_req)                                 w_gnt_ppu    = 1'b1;
          else if (cpu_wr_req)                                 w_gnt_cpu_wr = 1'b1;
          else if (cpu_rd_req)                                 w_gnt_cpu_rd = 1'b1;
        end
        if (w_gnt_ldr || w_gnt_cpu_wr || w_gnt_cpu_rd || w_gnt_ppu)
          w_state_next = c_st_issued;
      end
      c_st_issued: w_state_next = mc_busy ? c_st_busy : c_st_idle;
      c_st_busy:   if (!mc_busy) w_state_next = c_st_idle;
      default:     w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    mc_read_a  = w_gnt_cpu_rd;
    mc_read_b  = w_gnt_ppu;
    mc_write   = w_gnt_ldr | w_gnt_cpu_wr;
    cpu_ack    = w_gnt_cpu_rd | w_gnt_cpu_wr;
    ppu_ack    = w_gnt_ppu;
    w_sel_addr = '0;
    mc_din     = 8'd0;
    if (w_gnt_ldr) begin
      w_sel_addr = r_fifo_addr[r_rptr];
      mc_din     = r_fifo_data[r_rptr];
    end else if (w_gnt_cpu_wr) begin
      w_sel_addr = cpu_addr;
      mc_din     = cpu_wdata;
    end else if (w_gnt_cpu_rd) begin
      w_sel_addr = cpu_addr;
    end else if (w_gnt_ppu) begin
      w_sel_addr = ppu_addr;
    end
    mc_addr = 24'(w_sel_addr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count        <= 2'd0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_ldr_overflow <= 1'b0;
    end else begin
      if (w_enq) begin
        r_fifo_addr[r_wptr] <= ldr_addr;
        r_fifo_data[r_wptr] <= ldr_data;
        r_wptr              <= ~r_wptr;
      end
      if (w_deq) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
      if (ldr_wr && !w_enq) r_ldr_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_cpu_rd  <= 1'b0;
      r_op_ppu_rd  <= 1'b0;
      r_cpu_rdata  <= 8'd0;
      r_ppu_rdata  <= 8'd0;
      r_cpu_rvalid <= 1'b0;
      r_ppu_rvalid <= 1'b0;
      r_proto_err  <= 1'b0;
      r_starve     <= 3'd0;
    end else begin
      r_cpu_rvalid <= 1'b0;
      r_ppu_rvalid <= 1'b0;
      if (w_any_gnt) begin
        r_op_cpu_rd <= w_gnt_cpu_rd;
        r_op_ppu_rd <= w_gnt_ppu;
      end
      if (r_state == c_st_issued && !mc_busy) r_proto_err <= 1'b1;
      if (r_state == c_st_busy && !mc_busy) begin
        if (r_op_cpu_rd) begin
          r_cpu_rdata  <= mc_dout_a;
          r_cpu_rvalid <= 1'b1;
        end
        if (r_op_ppu_rd) begin
          r_ppu_rdata  <= mc_dout_b;
          r_ppu_rvalid <= 1'b1;
        end
      end
      if (!w_cpu_pend || cpu_ack)              r_starve <= 3'd0;
      else if (w_gnt_ppu && r_starve != 3'd7)  r_starve <= r_starve + 3'd1;
    end
  end

  assign ldr_overflow = r_ldr_overflow;
  assign proto_err    = r_proto_err;
  assign cpu_rdata    = r_cpu_rdata;
  assign cpu_rvalid   = r_cpu_rvalid;
  assign ppu_rdata    = r_ppu_rdata;
  assign ppu_rvalid   = r_ppu_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_psram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_arbiter
// Purpose  : Scoreboard bench for psram_arbiter with a simple controller model.
// Revision : 1.0
// ============================================================================
module tb_psram_arbiter;

  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ldr_wr = 1'b0;
  logic [ADDR_W-1:0] ldr_addr = '0;
  logic [7:0]        ldr_data = 8'd0;
  logic              ldr_overflow;
  logic              cpu_rd_req = 1'b0, cpu_wr_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_wdata = 8'd0;
  logic              cpu_ack, cpu_rvalid;
  logic [7:0]        cpu_rdata;
  logic              ppu_rd_req = 1'b0;
  logic [ADDR_W-1:0] ppu_addr = '0;
  logic              ppu_ack, ppu_rvalid;
  logic [7:0]        ppu_rdata;
  logic              mc_read_a, mc_read_b, mc_write;
  logic [23:0]       mc_addr;
  logic [7:0]        mc_din;
  logic              mc_busy = 1'b0;
  logic [7:0]        mc_dout_a = 8'd0, mc_dout_b = 8'd0;
  logic              proto_err;

  psram_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_overflow(ldr_overflow),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ppu_rd_req(ppu_rd_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack),
    .ppu_rdata(ppu_rdata), .ppu_rvalid(ppu_rvalid),
    .mc_read_a(mc_read_a), .mc_read_b(mc_read_b), .mc_write(mc_write),
    .mc_addr(mc_addr), .mc_din(mc_din), .mc_busy(mc_busy),
    .mc_dout_a(mc_dout_a), .mc_dout_b(mc_dout_b), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Kinds: 0 loader write, 1 CPU write, 2 CPU read, 3 PPU read. gap 0 = unchecked.
  typedef struct {
    int          kind;
    logic [23:0] addr;
    logic [7:0]  data;
    int          gap;
  } iss_t;

  iss_t       exp_iss[$];
  logic [7:0] exp_cpu[$];
  logic [7:0] exp_ppu[$];

  task automatic exp_issue(input int k, input logic [23:0] a, input logic [7:0] d, input int g);
    iss_t e;
    e.kind = k; e.addr = a; e.data = d; e.gap = g;
    exp_iss.push_back(e);
  endtask

  // Controller model: busy for busy_len cycles after a strobe, read data held on dout.
  logic [7:0]  mem [0:4095];
  logic        s_rd_a = 1'b0, s_rd_b = 1'b0, s_wr = 1'b0;
  logic [23:0] s_addr = 24'd0;
  logic [7:0]  s_din = 8'd0;
  int          busy_cnt = 0;
  int          busy_len = 3;
  bit          ignore_next = 1'b0;

  always @(negedge clk) begin
    s_rd_a = 1'b0; s_rd_b = 1'b0; s_wr = 1'b0;
    if (mc_read_a || mc_read_b || mc_write) begin
      if (ignore_next) ignore_next = 1'b0;
      else begin
        s_rd_a = mc_read_a; s_rd_b = mc_read_b; s_wr = mc_write;
        s_addr = mc_addr;   s_din  = mc_din;
      end
    end
  end

  always @(posedge clk) begin
    if (s_rd_a || s_rd_b || s_wr) begin
      busy_cnt <= busy_len;
      mc_busy  <= 1'b1;
      if (s_wr)   mem[s_addr[11:0]] <= s_din;
      if (s_rd_a) mc_dout_a <= mem[s_addr[11:0]];
      if (s_rd_b) mc_dout_b <= mem[s_addr[11:0]];
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      mc_busy  <= (busy_cnt > 1);
    end
  end

  int last_iss = -100, last_cpu_g = -100, last_ppu_g = -100;

  always @(negedge clk) begin : monitor
    int ns;
    int k;
    iss_t e;
    logic [7:0] d;
    if (cpu_rvalid) begin
      if (exp_cpu.size() == 0) chk(1'b0, "cpu_rvalid_unexpected", int'(cpu_rdata), 0);
      else begin
        d = exp_cpu.pop_front();
        chk(cpu_rdata == d, "cpu_rdata", int'(cpu_rdata), int'(d));
        chk(cyc - last_cpu_g == 5, "cpu_rvalid_latency", cyc - last_cpu_g, 5);
      end
    end
    if (ppu_rvalid) begin
      if (exp_ppu.size() == 0) chk(1'b0, "ppu_rvalid_unexpected", int'(ppu_rdata), 0);
      else begin
        d = exp_ppu.pop_front();
        chk(ppu_rdata == d, "ppu_rdata", int'(ppu_rdata), int'(d));
        chk(cyc - last_ppu_g == 5, "ppu_rvalid_latency", cyc - last_ppu_g, 5);
      end
    end
    ns = int'(mc_read_a) + int'(mc_read_b) + int'(mc_write);
    if (ns != 0) begin
      k = mc_write ? (cpu_ack ? 1 : 0) : (mc_read_a ? 2 : 3);
      chk(ns == 1, "strobe_onehot", ns, 1);
      if (exp_iss.size() == 0) chk(1'b0, "issue_unexpected", k, -1);
      else begin
        e = exp_iss.pop_front();
        chk(k == e.kind, "issue_kind", k, e.kind);
        chk(mc_addr == e.addr, "issue_addr", int'(mc_addr), int'(e.addr));
        if (k < 2) chk(mc_din == e.data, "issue_din", int'(mc_din), int'(e.data));
        chk(cpu_ack == (k == 1 || k == 2), "issue_cpu_ack", int'(cpu_ack), int'(k == 1 || k == 2));
        chk(ppu_ack == (k == 3), "issue_ppu_ack", int'(ppu_ack), int'(k == 3));
        if (e.gap != 0) chk(cyc - last_iss == e.gap, "issue_gap", cyc - last_iss, e.gap);
      end
      last_iss = cyc;
      if (k == 2) last_cpu_g = cyc;
      if (k == 3) last_ppu_g = cyc;
    end else if (cpu_ack || ppu_ack) begin
      chk(1'b0, "ack_without_strobe", int'({cpu_ack, ppu_ack}), 0);
    end
  end

  // Holds the current request lines, dropping each on its ack; the PPU is re-requested ppu_n times.
  task automatic run_reqs(input int ppu_n);
    int ppu_left;
    int budget;
    bit ca, pa;
    ppu_left = ppu_n;
    budget = 200;
    while ((cpu_rd_req || cpu_wr_req || ppu_rd_req) && budget > 0) begin
      @(negedge clk);
      ca = cpu_ack;
      pa = ppu_ack;
      @(posedge clk); #1;
      if (ca) begin
        if (cpu_wr_req) cpu_wr_req = 1'b0;
        else            cpu_rd_req = 1'b0;
      end
      if (pa) begin
        ppu_left--;
        if (ppu_left <= 0) ppu_rd_req = 1'b0;
      end
      budget--;
    end
    if (budget == 0) chk(1'b0, "request_timeout", int'({cpu_rd_req, cpu_wr_req, ppu_rd_req}), 0);
  endtask

  task automatic wait_idle();
    int quiet;
    int budget;
    quiet = 0;
    budget = 100;
    while (quiet < 3 && budget > 0) begin
      @(negedge clk);
      if (!mc_busy && exp_iss.size() == 0 && exp_cpu.size() == 0 && exp_ppu.size() == 0) quiet++;
      else quiet = 0;
      budget--;
    end
    if (quiet < 3) chk(1'b0, "idle_timeout", exp_iss.size() + exp_cpu.size() + exp_ppu.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({mc_read_a, mc_read_b, mc_write} == 3'b000, {tag, "_strobes"}, int'({mc_read_a, mc_read_b, mc_write}), 0);
    chk({cpu_ack, ppu_ack, cpu_rvalid, ppu_rvalid} == 4'b0000, {tag, "_ack_rvalid"},
        int'({cpu_ack, ppu_ack, cpu_rvalid, ppu_rvalid}), 0);
    chk(mc_addr == 24'd0 && mc_din == 8'd0, {tag, "_addr_din"}, int'(mc_addr), 0);
    chk(cpu_rdata == 8'd0, {tag, "_cpu_rdata"}, int'(cpu_rdata), 0);
    chk(ppu_rdata == 8'd0, {tag, "_ppu_rdata"}, int'(ppu_rdata), 0);
    chk(ldr_overflow == 1'b0, {tag, "_ldr_overflow"}, int'(ldr_overflow), 0);
    chk(proto_err == 1'b0, {tag, "_proto_err"}, int'(proto_err), 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h123] = 8'hA5;
    mem[12'h200] = 8'h3C;
    mem[12'h300] = 8'h5A;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Single CPU read.
    exp_issue(2, 24'h000123, 8'h00, 0);
    exp_cpu.push_back(8'hA5);
    @(posedge clk); #1;
    cpu_rd_req = 1'b1; cpu_addr = 22'h123;
    run_reqs(0);
    wait_idle();

    // Simultaneous CPU/PPU reads: PPU first, CPU five cycles later.
    exp_issue(3, 24'h000300, 8'h00, 0);
    exp_issue(2, 24'h000200, 8'h00, 5);
    exp_ppu.push_back(8'h5A);
    exp_cpu.push_back(8'h3C);
    @(posedge clk); #1;
    cpu_rd_req = 1'b1; cpu_addr = 22'h200;
    ppu_rd_req = 1'b1; ppu_addr = 22'h300;
    run_reqs(1);
    wait_idle();

    // Starvation guard: four PPU grants, then the CPU write, then the PPU again.
    exp_issue(3, 24'h000300, 8'h00, 0);
    for (int i = 0; i < 3; i++) exp_issue(3, 24'h000300, 8'h00, 5);
    exp_issue(1, 24'h000040, 8'h77, 5);
    for (int i = 0; i < 2; i++) exp_issue(3, 24'h000300, 8'h00, 5);
    for (int i = 0; i < 6; i++) exp_ppu.push_back(8'h5A);
    @(posedge clk); #1;
    ppu_rd_req = 1'b1; ppu_addr = 22'h300;
    cpu_wr_req = 1'b1; cpu_addr = 22'h040; cpu_wdata = 8'h77;
    run_reqs(6);
    wait_idle();

    exp_issue(2, 24'h000040, 8'h00, 0);
    exp_cpu.push_back(8'h77);
    @(posedge clk); #1;
    cpu_rd_req = 1'b1; cpu_addr = 22'h040;
    run_reqs(0);
    wait_idle();

    // Loader burst of three with CPU and PPU waiting: loader drains first, in order.
    exp_issue(0, 24'h001000, 8'h11, 0);
    exp_issue(0, 24'h001001, 8'h22, 5);
    exp_issue(0, 24'h001002, 8'h33, 5);
    exp_issue(3, 24'h000300, 8'h00, 5);
    exp_issue(2, 24'h000123, 8'h00, 5);
    exp_ppu.push_back(8'h5A);
    exp_cpu.push_back(8'hA5);
    @(posedge clk); #1;
    ldr_wr = 1'b1; ldr_addr = 22'h1000; ldr_data = 8'h11;
    @(posedge clk); #1;
    ldr_addr = 22'h1001; ldr_data = 8'h22;
    cpu_rd_req = 1'b1; cpu_addr = 22'h123;
    ppu_rd_req = 1'b1; ppu_addr = 22'h300;
    @(posedge clk); #1;
    ldr_addr = 22'h1002; ldr_data = 8'h33;
    @(posedge clk); #1;
    ldr_wr = 1'b0;
    run_reqs(1);
    wait_idle();
    chk(ldr_overflow == 1'b0, "burst_no_overflow", int'(ldr_overflow), 0);

    // Overflow: three pulses while a CPU read is in flight; the third is dropped.
    exp_issue(2, 24'h000123, 8'h00, 0);
    exp_issue(0, 24'h002000, 8'h44, 5);
    exp_issue(0, 24'h002001, 8'h55, 5);
    exp_cpu.push_back(8'hA5);
    @(posedge clk); #1;
    cpu_rd_req = 1'b1; cpu_addr = 22'h123;
    run_reqs(0);
    ldr_wr = 1'b1; ldr_addr = 22'h2000; ldr_data = 8'h44;
    @(posedge clk); #1;
    ldr_addr = 22'h2001; ldr_data = 8'h55;
    @(posedge clk); #1;
    ldr_addr = 22'h2002; ldr_data = 8'h66;
    @(posedge clk); #1;
    ldr_wr = 1'b0;
    wait_idle();
    chk(ldr_overflow == 1'b1, "overflow_sticky", int'(ldr_overflow), 1);

    // Protocol error: the controller ignores one strobe; next request issues right after.
    ignore_next = 1'b1;
    exp_issue(2, 24'h000123, 8'h00, 0);
    exp_issue(3, 24'h000300, 8'h00, 2);
    exp_ppu.push_back(8'h5A);
    @(posedge clk); #1;
    cpu_rd_req = 1'b1; cpu_addr = 22'h123;
    run_reqs(0);
    ppu_rd_req = 1'b1; ppu_addr = 22'h300;
    @(negedge clk);
    chk(proto_err == 1'b0, "proto_err_in_issued", int'(proto_err), 0);
    @(negedge clk);
    chk(proto_err == 1'b1, "proto_err_set", int'(proto_err), 1);
    chk(ppu_ack == 1'b1, "ppu_ack_after_proto_err", int'(ppu_ack), 1);
    @(posedge clk); #1;
    ppu_rd_req = 1'b0;
    wait_idle();

    // Reset in G+2 of a CPU read with a slow controller: no rvalid, grant waits for busy low.
    busy_len = 5;
    exp_issue(2, 24'h000200, 8'h00, 0);
    exp_issue(3, 24'h000300, 8'h00, 6);
    exp_ppu.push_back(8'h5A);
    @(posedge clk); #1;
    cpu_rd_req = 1'b1; cpu_addr = 22'h200;
    run_reqs(0);
    busy_len = 3;
    @(posedge clk); #1;
    reset = 1'b1;
    ppu_rd_req = 1'b1; ppu_addr = 22'h300;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    run_reqs(1);
    wait_idle();

    chk(exp_iss.size() == 0, "leftover_issues", exp_iss.size(), 0);
    chk(exp_cpu.size() == 0, "leftover_cpu_reads", exp_cpu.size(), 0);
    chk(exp_ppu.size() == 0, "leftover_ppu_reads", exp_ppu.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
